// File: rtl/pattern_pkg.sv
// pattern_pkg: pattern mode encoding and default visible-area size shared with the VGA timing generator.
// Contents: pattern_mode_t, DEF_H_ACTIVE, DEF_V_ACTIVE.
package pattern_pkg;
    typedef enum logic [1:0] {
        PAT_SOLID   = 2'd0,
        PAT_XOR     = 2'd1,
        PAT_BARS    = 2'd2,
        PAT_CHECKER = 2'd3
    } pattern_mode_t;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_V_ACTIVE = 480;
endpackage

// File: rtl/pattern_engine_if.sv
// pattern_engine_if: timing-position/control inputs and pixel outputs of the pattern engine.
// master (timing side): drives colPos, rowPos, mode_sel, speed, freeze; reads display_enable, color, frame_start.
// slave (pattern_engine): the mirror image.
interface pattern_engine_if #(parameter int COLOR_W = 6);
    import pattern_pkg::*;
    logic [9:0]         colPos;
    logic [9:0]         rowPos;
    pattern_mode_t      mode_sel;
    logic [3:0]         speed;
    logic               freeze;
    logic               display_enable;
    logic [COLOR_W-1:0] color;
    logic               frame_start;
    modport master (output colPos, rowPos, mode_sel, speed, freeze,
                    input  display_enable, color, frame_start);
    modport slave  (input  colPos, rowPos, mode_sel, speed, freeze,
                    output display_enable, color, frame_start);
endinterface

// File: rtl/pattern_engine_frame_ctrl.sv
// pattern_frame_ctrl: frame-start detect, scroll offset counter and per-frame mode latch.
// Ports: clk, rst_n (sync, active-low), col/row position, mode_sel, speed, freeze in;
//        fs (combinational frame start), offset and mode (values in force for the current pixel) out.
module pattern_frame_ctrl
    import pattern_pkg::*;
#(
    parameter int OFF_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [9:0]       col,
    input  logic [9:0]       row,
    input  pattern_mode_t    mode_sel,
    input  logic [3:0]       speed,
    input  logic             freeze,
    output logic             fs,
    output logic [OFF_W-1:0] offset,
    output pattern_mode_t    mode
);
    logic [9:0]       prev_col, prev_row;
    logic [OFF_W-1:0] offset_q;
    pattern_mode_t    mode_q;

    // Only the arrival at (0,0) counts, so a stalled origin yields one pulse.
    assign fs = col == '0 && row == '0 && (prev_col != '0 || prev_row != '0);
    // The frame-start pixel already uses the new offset and mode.
    assign offset = (fs && !freeze) ? offset_q + OFF_W'(speed) : offset_q;
    assign mode = fs ? mode_sel : mode_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_col <= '0;
            prev_row <= '0;
            offset_q <= '0;
            mode_q   <= PAT_XOR;
        end else begin
            prev_col <= col;
            prev_row <= row;
            offset_q <= offset;
            mode_q   <= mode;
        end
    end
endmodule

// File: rtl/pattern_engine.sv
// pattern_engine: VGA test-pattern source with four modes, frame-locked scrolling and border option.
// Ports: clk, rst_n (sync, active-low), bus (pattern_engine_if.slave: colPos, rowPos, mode_sel,
//        speed, freeze in; registered display_enable, color, frame_start out, 1-cycle latency).
// Optional: define PATTERN_BORDER_EN to force FG_COLOR on the outermost visible rows/columns.
module pattern_engine
    import pattern_pkg::*;
#(
    parameter int                 COLOR_W   = 6,
    parameter int                 H_ACTIVE  = DEF_H_ACTIVE,
    parameter int                 V_ACTIVE  = DEF_V_ACTIVE,
    parameter int                 OFF_W     = 10,
    parameter int                 CHK_SHIFT = 5,
    parameter int                 BAR_SHIFT = 6,
    parameter logic [COLOR_W-1:0] FG_COLOR  = '1,
    parameter logic [COLOR_W-1:0] BG_COLOR  = '0
) (
    input logic             clk,
    input logic             rst_n,
    pattern_engine_if.slave bus
);
    logic               fs;
    logic [OFF_W-1:0]   offset;
    pattern_mode_t      mode;
    logic [COLOR_W-1:0] off_hi, xor_c, bars_c, pat, pix;
    logic               chk, vis;

    pattern_frame_ctrl #(.OFF_W(OFF_W)) u_ctrl (
        .clk      (clk),
        .rst_n    (rst_n),
        .col      (bus.colPos),
        .row      (bus.rowPos),
        .mode_sel (bus.mode_sel),
        .speed    (bus.speed),
        .freeze   (bus.freeze),
        .fs       (fs),
        .offset   (offset),
        .mode     (mode)
    );

    // The top COLOR_W bits of the offset scroll the pattern slowly relative to speed.
    assign off_hi = offset[OFF_W-1 -: COLOR_W];
    assign xor_c  = ((bus.colPos[COLOR_W-1:0] + off_hi) ^ bus.rowPos[COLOR_W-1:0]) & COLOR_W'(8);
    assign bars_c = COLOR_W'(bus.colPos >> BAR_SHIFT) + off_hi;
    // Only bit 0 of the checker cell index decides the colour.
    assign chk    = bus.colPos[CHK_SHIFT] ^ bus.rowPos[CHK_SHIFT] ^ offset[OFF_W-1];
    assign vis    = bus.colPos < 10'(H_ACTIVE) && bus.rowPos < 10'(V_ACTIVE);

    always_comb begin
        pat = mode == PAT_SOLID ? FG_COLOR :
              mode == PAT_XOR   ? xor_c    :
              mode == PAT_BARS  ? bars_c   :
              (chk ? FG_COLOR : BG_COLOR);
`ifdef PATTERN_BORDER_EN
        pix = (bus.colPos == '0 || bus.colPos == 10'(H_ACTIVE - 1) ||
               bus.rowPos == '0 || bus.rowPos == 10'(V_ACTIVE - 1)) ? FG_COLOR : pat;
`else
        pix = pat;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.display_enable <= 1'b0;
            bus.color          <= '0;
            bus.frame_start    <= 1'b0;
        end else begin
            bus.display_enable <= vis;
            bus.color          <= vis ? pix : '0;
            bus.frame_start    <= fs;
        end
    end
endmodule

// File: tb/tb_pattern_engine.sv
// tb_pattern_engine: directed vectors and corner-case sequences for pattern_engine.
module tb_pattern_engine;
    import pattern_pkg::*;

    typedef struct {
        int col;
        int row;
        int de;
        int color;
        int fs;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
`ifdef PATTERN_BORDER_EN
    localparam bit BORDER = 1'b1;
`else
    localparam bit BORDER = 1'b0;
`endif

    pattern_engine_if bus ();
    pattern_engine dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic apply(input int c, input int r);
        bus.colPos = 10'(c);
        bus.rowPos = 10'(r);
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        apply(1, 0);
        apply(0, 0);
    endtask

    vec_t vecs[8];
    int   rows[5] = '{0, 1, 479, 480, 524};
    int   fs_exp[5] = '{1, 0, 0, 0, 0};
    int   bad, dec, fsc, edg;

    initial begin
        bus.mode_sel = PAT_SOLID;
        bus.speed    = 4'd0;
        bus.freeze   = 1'b0;
        vecs[0] = '{0, 0, 1, 63, 1};
        vecs[1] = '{0, 0, 1, 63, 0};
        vecs[2] = '{639, 479, 1, 63, 0};
        vecs[3] = '{640, 0, 0, 0, 0};
        vecs[4] = '{0, 480, 0, 0, 0};
        vecs[5] = '{799, 524, 0, 0, 0};
        vecs[6] = '{0, 0, 1, 63, 1};
        vecs[7] = '{320, 240, 1, 63, 0};

        // reset held with a visible position
        for (int i = 0; i < 3; i++) begin
            apply(5, 5);
            check($sformatf("rst_out[%0d]", i),
                  int'({bus.display_enable, bus.frame_start, bus.color}), 0);
        end
        check("rst_mode", int'(dut.u_ctrl.mode_q), int'(PAT_XOR));
        rst_n = 1'b1;

        // first frame after reset runs XOR even though mode_sel is SOLID
        apply(8, 0);
        check("xor_first_8_0", int'(bus.color), 8);
        apply(8, 8);
        check("xor_first_8_8", int'(bus.color), 0);

        apply(1, 0);
        foreach (vecs[i]) begin
            apply(vecs[i].col, vecs[i].row);
            check($sformatf("vec%0d_de", i), int'(bus.display_enable), vecs[i].de);
            check($sformatf("vec%0d_color", i), int'(bus.color), vecs[i].color);
            check($sformatf("vec%0d_fs", i), int'(bus.frame_start), vecs[i].fs);
        end

        // sampled-row sweep over the whole line width, SOLID mode
        bad = 0; dec = 0; fsc = 0;
        foreach (rows[k]) begin
            for (int c = 0; c < 800; c++) begin
                apply(c, rows[k]);
                edg = (c < 640 && rows[k] < 480) ? 1 : 0;
                if (int'(bus.display_enable) != edg || int'(bus.color) != (edg != 0 ? 63 : 0)) bad++;
                dec += int'(bus.display_enable);
                fsc += int'(bus.frame_start);
            end
        end
        check("sweep_pix_bad", bad, 0);
        check("sweep_de_count", dec, 1920);
        check("sweep_fs_count", fsc, 1);

        // scrolling offset
        bus.speed = 4'd4;
        for (int i = 1; i <= 3; i++) begin
            frame();
            check($sformatf("offset_f%0d", i), int'(dut.u_ctrl.offset_q), 4 * i);
        end
        for (int i = 0; i < 252; i++) frame();
        check("offset_1020", int'(dut.u_ctrl.offset_q), 1020);

        // mode change mid-frame applies only from the next frame (offset 1020 has bit 9 set)
        bus.speed = 4'd0;
        bus.mode_sel = PAT_XOR;
        frame();
        apply(99, 200);
        bus.mode_sel = PAT_CHECKER;
        apply(100, 200);
        check("midframe_xor_100", int'(bus.color), 8);
        apply(101, 200);
        check("midframe_xor_101", int'(bus.color), 8);
        apply(0, 0);
        check("chk_0_0", int'(bus.color), 63);
        check("chk_fs", int'(bus.frame_start), 1);
        apply(32, 0);
        check("chk_32_0", int'(bus.color), BORDER ? 63 : 0);
        apply(32, 1);
        check("chk_32_1", int'(bus.color), 0);

        bus.speed = 4'd4;
        frame();
        check("offset_wrap", int'(dut.u_ctrl.offset_q), 0);
        bus.freeze = 1'b1;
        frame();
        check("offset_frozen", int'(dut.u_ctrl.offset_q), 0);
        bus.freeze = 1'b0;

        // stalled origin gives one pulse and one increment
        apply(5, 5);
        for (int i = 0; i < 5; i++) begin
            apply(0, 0);
            check($sformatf("hold_fs[%0d]", i), int'(bus.frame_start), fs_exp[i]);
        end
        apply(1, 0);
        check("hold_fs_after", int'(bus.frame_start), 0);
        check("hold_offset", int'(dut.u_ctrl.offset_q), 4);

        // bars (offset 4 leaves the upper offset bits at zero)
        bus.speed = 4'd0;
        bus.mode_sel = PAT_BARS;
        frame();
        apply(639, 10);
        check("bars_639_10", int'(bus.color), BORDER ? 63 : 9);
        apply(10, 479);
        check("bars_10_479", int'(bus.color), BORDER ? 63 : 0);
        apply(64, 10);
        check("bars_64_10", int'(bus.color), 1);
        apply(200, 10);
        check("bars_200_10", int'(bus.color), 3);

        // reset mid-frame
        apply(200, 100);
        check("pre_rst_de", int'(bus.display_enable), 1);
        rst_n = 1'b0;
        apply(300, 100);
        check("midrst_out", int'({bus.display_enable, bus.frame_start, bus.color}), 0);
        rst_n = 1'b1;
        apply(1, 0);
        check("post_rst_fs0", int'(bus.frame_start), 0);
        apply(0, 0);
        check("post_rst_fs1", int'(bus.frame_start), 1);
        apply(64, 10);
        check("post_rst_bars", int'(bus.color), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
